// File: rtl/stream_ctrl_mc.sv
// stream_ctrl_mc -- multi-channel whole-frame stream start/stop controller.
//
// Sits in the sensor pixel clock domain between the deserialiser and the sync
// buffer. Each frame is either forwarded whole or dropped whole. The decision
// is taken once, at the fval rising edge, from the registered enable term
// (se & acq & encrypt). In SINGLE_FRAME mode each rising edge of acq arms
// exactly one frame. Input-to-output latency is 2 cycles: stage 1 registers
// the inputs and stage 2 is the output register.
//
// Optional feature, macro STREAM_CTRL_MC_BLANK_CHECK_EN: a frame that starts
// after fewer than MIN_BLANK fval-low cycles is dropped. o_blank_err pulses for
// one cycle when such a frame would otherwise have been passed. Without the
// macro any blanking length is accepted and o_blank_err is constant 0.
//
// Ports:
//   clk_sensor_pix      sensor pixel clock (rising edge)
//   reset_sensor_n      asynchronous active-low reset
//   i_fval / i_lval     frame / line valid from the sensor
//   iv_pix_data         CHANNEL_NUM x DATA_WIDTH pixels, channel 0 in the LSBs
//   i_stream_enable, i_acquisition_start, i_encrypt_state   enable levels
//   o_fval / o_lval     gated frame / line valid
//   ov_pix_data         gated pixels, zero when not passing
//   o_full_frame_state  high while a passed frame is in flight
//   ov_frame_cnt        completed passed frames, wraps
//   o_blank_err         one-cycle blanking-violation pulse

// Per-channel data path: stage-1 capture, then gated output register.
module stream_ctrl_mc_lane #(
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk_sensor_pix,
  input  logic                  reset_sensor_n,
  input  logic [DATA_WIDTH-1:0] iv_pix,
  input  logic                  i_pass,
  output logic [DATA_WIDTH-1:0] ov_pix
);
  logic [DATA_WIDTH-1:0] r_pix1, r_pix2;

  always_ff @(posedge clk_sensor_pix or negedge reset_sensor_n) begin
    if (!reset_sensor_n) begin
      r_pix1 <= '0;
      r_pix2 <= '0;
    end else begin
      r_pix1 <= iv_pix;
      r_pix2 <= i_pass ? r_pix1 : '0;
    end
  end

  assign ov_pix = r_pix2;
endmodule

module stream_ctrl_mc #(
  parameter int    DATA_WIDTH   = 10,
  parameter int    CHANNEL_NUM  = 1,
  parameter string ACQ_MODE     = "CONTINUOUS",
  parameter int    FRAME_CNT_WD = 16,
  parameter int    MIN_BLANK    = 3
) (
  input  logic                              clk_sensor_pix,
  input  logic                              reset_sensor_n,
  input  logic                              i_fval,
  input  logic                              i_lval,
  input  logic [DATA_WIDTH*CHANNEL_NUM-1:0] iv_pix_data,
  input  logic                              i_stream_enable,
  input  logic                              i_acquisition_start,
  input  logic                              i_encrypt_state,
  output logic                              o_fval,
  output logic                              o_lval,
  output logic [DATA_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
  output logic                              o_full_frame_state,
  output logic [FRAME_CNT_WD-1:0]           ov_frame_cnt,
  output logic                              o_blank_err
);
  localparam bit SINGLE = (ACQ_MODE == "SINGLE_FRAME");

  typedef enum logic [1:0] {S_IDLE, S_PASS, S_SKIP} state_t;
  state_t r_state, w_state_nxt;

  logic r_fval1, r_fval2, r_lval1, r_en1, r_acq1, r_acq2, r_armed;
  logic r_fval_o, r_lval_o, r_ffs, r_blank_err;
  logic [FRAME_CNT_WD-1:0] r_frame_cnt;
  logic w_start, w_gate, w_blank_ok, w_enter_pass, w_frame_done, w_blank_err;
  logic w_acq_rise, w_pass_nxt;
  logic [CHANNEL_NUM-1:0][DATA_WIDTH-1:0] w_pix_in, w_pix_out;

  // Stage 1. fval_r1/fval_r2 come out of reset as 1 so that a reset released
  // mid-frame never looks like a frame start; the next start needs a real low.
  always_ff @(posedge clk_sensor_pix or negedge reset_sensor_n) begin
    if (!reset_sensor_n) begin
      r_fval1 <= 1'b1;
      r_fval2 <= 1'b1;
      r_lval1 <= 1'b0;
      r_en1   <= 1'b0;
      r_acq1  <= 1'b0;
      r_acq2  <= 1'b0;
    end else begin
      r_fval1 <= i_fval;
      r_fval2 <= r_fval1;
      r_lval1 <= i_lval;
      r_en1   <= i_stream_enable & i_acquisition_start & i_encrypt_state;
      r_acq1  <= i_acquisition_start;
      r_acq2  <= r_acq1;
    end
  end

  assign w_start    = r_fval1 & ~r_fval2;
  assign w_acq_rise = r_acq1 & ~r_acq2;
  assign w_gate     = r_en1 & (SINGLE ? r_armed : 1'b1);

`ifdef STREAM_CTRL_MC_BLANK_CHECK_EN
  localparam int BW = (MIN_BLANK < 1) ? 1 : $clog2(MIN_BLANK + 1);
  logic [BW-1:0] r_blank_cnt;

  // Counts fval_r1-low cycles, saturating; holds the gap length at the start edge.
  always_ff @(posedge clk_sensor_pix or negedge reset_sensor_n) begin
    if (!reset_sensor_n)                 r_blank_cnt <= BW'(MIN_BLANK);
    else if (r_fval1)                    r_blank_cnt <= '0;
    else if (r_blank_cnt < BW'(MIN_BLANK)) r_blank_cnt <= r_blank_cnt + 1'b1;
  end

  assign w_blank_ok = (r_blank_cnt >= BW'(MIN_BLANK));
`else
  // No blanking check: every gap length is accepted.
  assign w_blank_ok = (MIN_BLANK >= 0) | 1'b1;
`endif

  // Next-state logic. PASS/SKIP leave on the fval_r1 fall; a new start edge
  // needs at least one low cycle, so it always lands in IDLE.
  always_comb begin
    w_state_nxt  = r_state;
    w_enter_pass = 1'b0;
    w_frame_done = 1'b0;
    w_blank_err  = 1'b0;
    case (r_state)
      S_IDLE: if (w_start) begin
        w_blank_err = w_gate & ~w_blank_ok;
        if (w_gate && w_blank_ok) begin
          w_state_nxt  = S_PASS;
          w_enter_pass = 1'b1;
        end else begin
          w_state_nxt  = S_SKIP;
        end
      end
      S_PASS: if (!r_fval1) begin
        w_state_nxt  = S_IDLE;
        w_frame_done = 1'b1;
      end
      S_SKIP: if (!r_fval1) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_pass_nxt = (w_state_nxt == S_PASS) & r_fval1;

  always_ff @(posedge clk_sensor_pix or negedge reset_sensor_n) begin
    if (!reset_sensor_n) begin
      r_state     <= S_IDLE;
      r_armed     <= 1'b0;
      r_fval_o    <= 1'b0;
      r_lval_o    <= 1'b0;
      r_ffs       <= 1'b0;
      r_blank_err <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      // A new acq edge in the same cycle as a PASS entry re-arms for the next frame.
      r_armed     <= w_acq_rise | (r_armed & ~w_enter_pass);
      r_fval_o    <= w_pass_nxt;
      r_lval_o    <= w_pass_nxt & r_lval1;
      r_ffs       <= (w_state_nxt == S_PASS);
      r_blank_err <= w_blank_err;
      if (w_frame_done) r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign w_pix_in = iv_pix_data;

  for (genvar g = 0; g < CHANNEL_NUM; g++) begin : g_lane
    stream_ctrl_mc_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk_sensor_pix (clk_sensor_pix),
      .reset_sensor_n (reset_sensor_n),
      .iv_pix         (w_pix_in[g]),
      .i_pass         (w_pass_nxt),
      .ov_pix         (w_pix_out[g])
    );
  end

  assign o_fval             = r_fval_o;
  assign o_lval             = r_lval_o;
  assign ov_pix_data        = w_pix_out;
  assign o_full_frame_state = r_ffs;
  assign ov_frame_cnt       = r_frame_cnt;
  assign o_blank_err        = r_blank_err;
endmodule

// File: tb/tb_stream_ctrl_mc.sv
// Bench for stream_ctrl_mc: one CONTINUOUS and one SINGLE_FRAME instance share
// the same stimulus. A frame-level model predicts every output each cycle.
module tb_stream_ctrl_mc;
  localparam int DW = 10;
  localparam int CN = 2;
  localparam int PW = DW * CN;
  localparam int MINB = 3;
`ifdef STREAM_CTRL_MC_BLANK_CHECK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  typedef struct packed {
    logic          fval;
    logic          lval;
    logic [PW-1:0] pix;
    logic          ffs;
    logic [15:0]   cnt;
    logic          berr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fval = 1'b0, lval = 1'b0, se = 1'b0, acq = 1'b0, enc = 1'b0;
  logic [PW-1:0] pix = '0;

  logic          o_fval[2], o_lval[2], o_ffs[2], o_berr[2];
  logic [PW-1:0] o_pix[2];
  logic [15:0]   o_cnt[2];

  int n_cmp = 0, n_err = 0;
  int rise_c = 0, berr_c = 0;
  logic prev_of = 1'b0;

  always #5 clk = ~clk;

  stream_ctrl_mc #(.DATA_WIDTH(DW), .CHANNEL_NUM(CN), .ACQ_MODE("CONTINUOUS"),
                   .FRAME_CNT_WD(16), .MIN_BLANK(MINB)) u_cont (
    .clk_sensor_pix(clk), .reset_sensor_n(rst_n), .i_fval(fval), .i_lval(lval),
    .iv_pix_data(pix), .i_stream_enable(se), .i_acquisition_start(acq),
    .i_encrypt_state(enc), .o_fval(o_fval[0]), .o_lval(o_lval[0]),
    .ov_pix_data(o_pix[0]), .o_full_frame_state(o_ffs[0]),
    .ov_frame_cnt(o_cnt[0]), .o_blank_err(o_berr[0]));

  stream_ctrl_mc #(.DATA_WIDTH(DW), .CHANNEL_NUM(CN), .ACQ_MODE("SINGLE_FRAME"),
                   .FRAME_CNT_WD(16), .MIN_BLANK(MINB)) u_single (
    .clk_sensor_pix(clk), .reset_sensor_n(rst_n), .i_fval(fval), .i_lval(lval),
    .iv_pix_data(pix), .i_stream_enable(se), .i_acquisition_start(acq),
    .i_encrypt_state(enc), .o_fval(o_fval[1]), .o_lval(o_lval[1]),
    .ov_pix_data(o_pix[1]), .o_full_frame_state(o_ffs[1]),
    .ov_frame_cnt(o_cnt[1]), .o_blank_err(o_berr[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  // Per sampled input cycle: a frame starts where fval goes high after a low;
  // the whole frame is passed or dropped from what held at that moment.
  int   m_low;
  logic m_prev_f, m_prev_acq;
  logic m_pass[2], m_armed[2];
  logic [15:0] m_cnt[2];
  exp_t exp_now[2], exp_pend[2];

  always @(posedge clk) begin
    logic en, start, gate, ok, berr;
    if (!rst_n) begin
      m_low = MINB; m_prev_f = 1'b1; m_prev_acq = 1'b0;
      for (int m = 0; m < 2; m++) begin
        m_pass[m] = 1'b0; m_armed[m] = 1'b0; m_cnt[m] = '0;
        exp_now[m] = '0; exp_pend[m] = '0;
      end
    end else begin
      en    = se & acq & enc;
      start = fval & ~m_prev_f;
      for (int m = 0; m < 2; m++) begin
        exp_now[m] = exp_pend[m];
        berr = 1'b0;
        if (start) begin
          gate = en & ((m == 0) ? 1'b1 : m_armed[m]);
          ok   = !BLANK_EN || (m_low >= MINB);
          m_pass[m] = gate & ok;
          berr = gate & ~ok;
          if (m_pass[m]) m_armed[m] = 1'b0;
        end
        if (!fval && m_pass[m]) begin
          m_cnt[m]  = m_cnt[m] + 16'd1;
          m_pass[m] = 1'b0;
        end
        exp_pend[m].fval = m_pass[m] & fval;
        exp_pend[m].lval = m_pass[m] & fval & lval;
        exp_pend[m].pix  = (m_pass[m] & fval) ? pix : '0;
        exp_pend[m].ffs  = m_pass[m];
        exp_pend[m].cnt  = m_cnt[m];
        exp_pend[m].berr = berr;
      end
      if (acq && !m_prev_acq) begin
        m_armed[0] = 1'b1; m_armed[1] = 1'b1;
      end
      m_low      = fval ? 0 : ((m_low < MINB) ? m_low + 1 : m_low);
      m_prev_f   = fval;
      m_prev_acq = acq;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    exp_t e;
    for (int m = 0; m < 2; m++) begin
      e = rst_n ? exp_now[m] : '0;
      chk($sformatf("fval[%0d]", m), 32'(o_fval[m]), 32'(e.fval));
      chk($sformatf("lval[%0d]", m), 32'(o_lval[m]), 32'(e.lval));
      chk($sformatf("pix[%0d]",  m), 32'(o_pix[m]),  32'(e.pix));
      chk($sformatf("ffs[%0d]",  m), 32'(o_ffs[m]),  32'(e.ffs));
      chk($sformatf("cnt[%0d]",  m), 32'(o_cnt[m]),  32'(e.cnt));
      chk($sformatf("berr[%0d]", m), 32'(o_berr[m]), 32'(e.berr));
    end
    if (o_fval[0] && !prev_of) rise_c++;
    if (o_berr[0]) berr_c++;
    prev_of = o_fval[0];
  end

  // ---------------- stimulus ----------------
  // Starts and ends at a falling clock edge. chg_line switches se at the start
  // of that line; rst_line pulses reset in the middle of that frame.
  task automatic send_frame(input int lines, input int px, input int vblank,
                            input int chg_line, input logic chg_val, input int rst_line);
    for (int ln = 0; ln < lines; ln++) begin
      if (ln == chg_line) se = chg_val;
      if (ln == rst_line) begin
        #2 rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
          chk($sformatf("rst_fval[%0d]", m), 32'(o_fval[m]), 32'd0);
          chk($sformatf("rst_pix[%0d]",  m), 32'(o_pix[m]),  32'd0);
          chk($sformatf("rst_cnt[%0d]",  m), 32'(o_cnt[m]),  32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
      end
      for (int p = 0; p < px; p++) begin
        fval = 1'b1; lval = 1'b1; pix = PW'($urandom);
        @(negedge clk);
      end
      fval = 1'b1; lval = 1'b0; pix = PW'($urandom);
      @(negedge clk);
    end
    for (int v = 0; v < vblank; v++) begin
      // A stray lval pulse in blanking must never reach the output.
      fval = 1'b0; lval = (v == 0); pix = PW'($urandom);
      @(negedge clk);
    end
    lval = 1'b0;
  endtask

  initial begin
    int r0, e0, c0;
    repeat (3) @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("reset_fval[%0d]", m), 32'(o_fval[m]), 32'd0);
      chk($sformatf("reset_ffs[%0d]",  m), 32'(o_ffs[m]),  32'd0);
      chk($sformatf("reset_cnt[%0d]",  m), 32'(o_cnt[m]),  32'd0);
    end
    rst_n = 1'b1;
    se = 1'b1; acq = 1'b1; enc = 1'b1;
    repeat (5) @(negedge clk);

    // 30 full 64x64 frames (2 pixels per cycle)
    for (int f = 0; f < 30; f++) send_frame(64, 32, 4, -1, 1'b0, -1);
    repeat (2) @(negedge clk);
    chk("cont_30_frames", 32'(o_cnt[0]), 32'd30);
    chk("single_one_frame", 32'(o_cnt[1]), 32'd1);

    // enable changes mid-frame
    send_frame(8, 8, 6, 3, 1'b0, -1);   // se drops mid-frame: completes
    send_frame(8, 8, 6, -1, 1'b0, -1);  // se low at start: dropped
    send_frame(8, 8, 6, 4, 1'b1, -1);   // se rises mid-frame: dropped
    send_frame(8, 8, 6, -1, 1'b0, -1);  // passed
    chk("cont_se_mid", 32'(o_cnt[0]), 32'd32);
    chk("single_se_mid", 32'(o_cnt[1]), 32'd1);

    // single-frame: two acq edges in one blank arm only one frame
    acq = 1'b0; repeat (3) @(negedge clk);
    acq = 1'b1; repeat (2) @(negedge clk);
    acq = 1'b0; repeat (2) @(negedge clk);
    acq = 1'b1; repeat (3) @(negedge clk);
    send_frame(4, 4, 6, -1, 1'b0, -1);
    send_frame(4, 4, 6, -1, 1'b0, -1);
    chk("single_double_acq", 32'(o_cnt[1]), 32'd2);
    acq = 1'b0; repeat (2) @(negedge clk);
    acq = 1'b1; repeat (3) @(negedge clk);
    send_frame(4, 4, 6, -1, 1'b0, -1);
    send_frame(4, 4, 6, -1, 1'b0, -1);
    chk("single_rearm", 32'(o_cnt[1]), 32'd3);
    chk("cont_acq_sect", 32'(o_cnt[0]), 32'd36);

    // short blanking gaps of 1, 2 and 3 cycles
    r0 = rise_c; e0 = berr_c; c0 = int'(o_cnt[0]);
    send_frame(4, 4, 1, -1, 1'b0, -1);
    send_frame(4, 4, 8, -1, 1'b0, -1);
    send_frame(4, 4, 2, -1, 1'b0, -1);
    send_frame(4, 4, 8, -1, 1'b0, -1);
    send_frame(4, 4, 3, -1, 1'b0, -1);
    send_frame(4, 4, 8, -1, 1'b0, -1);
    chk("gap_rises", 32'(rise_c - r0), BLANK_EN ? 32'd4 : 32'd6);
    chk("gap_blank_err", 32'(berr_c - e0), BLANK_EN ? 32'd2 : 32'd0);
    chk("gap_cnt", 32'(int'(o_cnt[0]) - c0), BLANK_EN ? 32'd4 : 32'd6);

    // reset mid-PASS, released with fval high
    send_frame(8, 8, 6, -1, 1'b0, 3);
    chk("post_rst_partial", 32'(o_cnt[0]), 32'd0);
    r0 = rise_c;
    send_frame(8, 8, 6, -1, 1'b0, -1);
    chk("post_rst_cont", 32'(o_cnt[0]), 32'd1);
    chk("post_rst_single", 32'(o_cnt[1]), 32'd1);
    chk("post_rst_rises", 32'(rise_c - r0), 32'd1);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
